// File: rtl/frame_write_sequencer.sv
// Frame write sequencer: grants draw sources one at a time, in ascending index order, and forwards their pixels to a registered framebuffer write port.
// Optional per-slot watchdog with a timeout output port: enabled by defining FRAME_WRITE_TIMEOUT_EN.
module frame_write_sequencer #(
  parameter int NUM_SOURCES    = 4,
  parameter int COLOR_DEPTH    = 9,
  parameter int COORD_W        = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame,
  input  logic [NUM_SOURCES-1:0]             src_enable,
  input  logic [NUM_SOURCES-1:0]             src_valid,
  input  logic [NUM_SOURCES-1:0]             src_done,
  input  logic [NUM_SOURCES-1:0]             src_transparent,
  input  logic [NUM_SOURCES*COORD_W-1:0]     src_x,
  input  logic [NUM_SOURCES*COORD_W-1:0]     src_y,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
  output logic [NUM_SOURCES-1:0]             src_ready,
  output logic [$clog2(NUM_SOURCES)-1:0]     sel,
  output logic                               wr_en,
  output logic [COORD_W-1:0]                 wr_x,
  output logic [COORD_W-1:0]                 wr_y,
  output logic [COLOR_DEPTH-1:0]             wr_color,
  output logic                               busy,
`ifdef FRAME_WRITE_TIMEOUT_EN
  output logic                               timeout,
`endif
  output logic                               overrun
);

  localparam int SEL_W = $clog2(NUM_SOURCES);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SOURCES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, RUN} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] sel_next;
  logic             overrun_next;
  logic             slot_end;
  logic             xfer;
  logic             opaque_xfer;

`ifdef FRAME_WRITE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] run_cnt;
  logic             timeout_hit;
  logic             timeout_next;

  assign timeout_hit = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is zero in every cycle that is not RUN, so it is clear on RUN entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
      timeout <= timeout_next;
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    sel_next     = sel;
    overrun_next = 1'b0;
    slot_end     = 1'b0;
`ifdef FRAME_WRITE_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (frame) begin
          state_next = SELECT;
          sel_next   = '0;
        end
      end
      SELECT: begin
        if (frame) begin
          overrun_next = 1'b1;
          sel_next     = '0;
        end else if (src_enable[sel]) begin
          state_next = RUN;
        end else begin
          slot_end = 1'b1;
        end
      end
      RUN: begin
        if (frame) begin
          overrun_next = 1'b1;
          state_next   = SELECT;
          sel_next     = '0;
        end else if (src_done[sel]) begin
          slot_end = 1'b1;
`ifdef FRAME_WRITE_TIMEOUT_EN
        end else if (timeout_hit) begin
          slot_end     = 1'b1;
          timeout_next = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    // Ending a slot (done, skip or watchdog) moves to the next index or finishes the pass.
    if (slot_end) begin
      if (sel == LAST_SEL) begin
        state_next = IDLE;
        sel_next   = '0;
      end else begin
        state_next = SELECT;
        sel_next   = sel + SEL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      sel     <= sel_next;
      overrun <= overrun_next;
    end
  end

  always_comb begin
    src_ready = '0;
    if (state == RUN) src_ready[sel] = 1'b1;
  end

  assign busy        = (state != IDLE);
  assign xfer        = (state == RUN) && src_valid[sel];
  assign opaque_xfer = xfer && !src_transparent[sel];

  // Write port: one registered stage; data holds its last value between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
    end else begin
      wr_en <= opaque_xfer;
      if (opaque_xfer) begin
        wr_x     <= src_x[int'(sel)*COORD_W +: COORD_W];
        wr_y     <= src_y[int'(sel)*COORD_W +: COORD_W];
        wr_color <= src_color[int'(sel)*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed self-checking bench for frame_write_sequencer (4 sources, 9-bit colour, 10-bit coordinates).
// Watchdog scenario is exercised only when FRAME_WRITE_TIMEOUT_EN is defined.
module tb_frame_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame;
  logic [3:0]  src_enable, src_valid, src_done, src_transparent;
  logic [39:0] src_x, src_y;
  logic [35:0] src_color;
  logic [3:0]  src_ready;
  logic [1:0]  sel;
  logic        wr_en;
  logic [9:0]  wr_x, wr_y;
  logic [8:0]  wr_color;
  logic        busy, overrun;
`ifdef FRAME_WRITE_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  frame_write_sequencer #(
    .NUM_SOURCES(4), .COLOR_DEPTH(9), .COORD_W(10), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .frame(frame),
    .src_enable(src_enable), .src_valid(src_valid), .src_done(src_done),
    .src_transparent(src_transparent),
    .src_x(src_x), .src_y(src_y), .src_color(src_color),
    .src_ready(src_ready), .sel(sel),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .busy(busy),
`ifdef FRAME_WRITE_TIMEOUT_EN
    .timeout(timeout),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0; src_done = '0; src_transparent = '0;
    src_x = '0; src_y = '0; src_color = '0;
  endtask

  task automatic set_pix(input int s, input logic [9:0] x, input logic [9:0] y,
                         input logic [8:0] c);
    src_x[s*10 +: 10]    = x;
    src_y[s*10 +: 10]    = y;
    src_color[s*9 +: 9]  = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame = 1'b1; src_enable = 4'hF; clear_src();
    #1;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (sel !== 2'd0)     begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    n_checks++; if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    n_checks++; if (src_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", src_ready); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    n_checks++; if ({wr_x, wr_y, wr_color} !== 29'd0) begin n_fail++; $display("FAIL reset_wr_data: got %0h expected 0", {wr_x, wr_y, wr_color}); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ignored: busy got %0b expected 0", busy); end
    frame = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: busy got %0b expected 0", busy); end
  endtask

  // All four sources, three opaque pixels each; done rides with the third pixel.
  // Non-granted sources assert valid/done/transparent noise that must be ignored.
  task automatic test_full_pass();
    logic [9:0] last_x;
    src_enable = 4'hF; frame = 1'b1;
    tick();
    frame = 1'b0;
    last_x = '0;
    for (int s = 0; s < 4; s++) begin
      n_checks++; if (sel !== 2'(s)) begin n_fail++; $display("FAIL pass_select_sel: got %0d expected %0d", sel, s); end
      n_checks++; if (src_ready !== 4'h0) begin n_fail++; $display("FAIL pass_select_ready: got %0h expected 0", src_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy: got %0b expected 1", busy); end
      n_checks++; if (wr_en !== (s > 0)) begin n_fail++; $display("FAIL pass_select_wr_en src%0d: got %0b expected %0b", s, wr_en, s > 0); end
      if (s > 0) begin
        n_checks++; if (wr_x !== last_x) begin n_fail++; $display("FAIL pass_last_x src%0d: got %0d expected %0d", s, wr_x, last_x); end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (src_ready !== 4'(1 << s)) begin n_fail++; $display("FAIL pass_run_ready src%0d: got %0h expected %0h", s, src_ready, 4'(1 << s)); end
        n_checks++; if (wr_en !== (k > 0)) begin n_fail++; $display("FAIL pass_run_wr_en src%0d pix%0d: got %0b expected %0b", s, k, wr_en, k > 0); end
        if (k > 0) begin
          n_checks++;
          if (wr_x !== 10'(s*16 + k - 1) || wr_y !== 10'(k) || wr_color !== 9'(s*4 + k - 1)) begin
            n_fail++;
            $display("FAIL pass_data src%0d pix%0d: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)", s, k - 1,
                     wr_x, wr_y, wr_color, s*16 + k - 1, k, s*4 + k - 1);
          end
        end
        clear_src();
        src_x = '1; src_y = '1; src_color = '1;
        src_valid       = 4'hF;
        src_transparent = ~4'(1 << s);
        src_done        = ~4'(1 << s) | ((k == 2) ? 4'(1 << s) : 4'h0);
        set_pix(s, 10'(s*16 + k), 10'(k + 1), 9'(s*4 + k));
        last_x = 10'(s*16 + k);
        tick();
        clear_src();
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pass_end_busy: got %0b expected 0", busy); end
    n_checks++; if (wr_en !== 1'b1 || wr_x !== 10'd50) begin n_fail++; $display("FAIL pass_final_write: got en=%0b x=%0d expected en=1 x=50", wr_en, wr_x); end
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL pass_idle_wr_en: got %0b expected 0", wr_en); end
  endtask

  task automatic test_skip();
    src_enable = 4'b1010; frame = 1'b1;
    tick();
    frame = 1'b0;
    n_checks++; if (sel !== 2'd0 || src_ready !== 4'h0) begin n_fail++; $display("FAIL skip_sel0: got sel=%0d ready=%0h expected sel=0 ready=0", sel, src_ready); end
    tick();
    n_checks++; if (sel !== 2'd1 || src_ready !== 4'h0) begin n_fail++; $display("FAIL skip_select1: got sel=%0d ready=%0h expected sel=1 ready=0", sel, src_ready); end
    tick();
    n_checks++; if (sel !== 2'd1 || src_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_run1: got sel=%0d ready=%0h expected sel=1 ready=2", sel, src_ready); end
    src_done = 4'b0010;
    tick();
    clear_src();
    n_checks++; if (sel !== 2'd2 || src_ready !== 4'h0) begin n_fail++; $display("FAIL skip_sel2: got sel=%0d ready=%0h expected sel=2 ready=0", sel, src_ready); end
    tick();
    n_checks++; if (sel !== 2'd3 || src_ready !== 4'h0) begin n_fail++; $display("FAIL skip_select3: got sel=%0d ready=%0h expected sel=3 ready=0", sel, src_ready); end
    tick();
    n_checks++; if (sel !== 2'd3 || src_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_run3: got sel=%0d ready=%0h expected sel=3 ready=8", sel, src_ready); end
    src_done = 4'b1000;
    tick();
    clear_src();
    n_checks++; if (busy !== 1'b0 || src_ready !== 4'h0) begin n_fail++; $display("FAIL skip_end: got busy=%0b ready=%0h expected busy=0 ready=0", busy, src_ready); end
  endtask

  task automatic test_transparent();
    src_enable = 4'b0010; frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    tick();
    n_checks++; if (src_ready !== 4'b0010) begin n_fail++; $display("FAIL transp_ready: got %0h expected 2", src_ready); end
    src_valid = 4'b0010; src_transparent = 4'b0010;
    set_pix(1, 10'd5, 10'd7, 9'h1FF);
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL transp_no_write: got %0b expected 0", wr_en); end
    src_transparent = 4'b0000;
    set_pix(1, 10'd6, 10'd7, 9'h0AA);
    tick();
    clear_src();
    n_checks++;
    if (wr_en !== 1'b1 || wr_x !== 10'd6 || wr_y !== 10'd7 || wr_color !== 9'h0AA) begin
      n_fail++;
      $display("FAIL transp_write: got en=%0b (%0d,%0d,%0h) expected en=1 (6,7,aa)", wr_en, wr_x, wr_y, wr_color);
    end
    src_done = 4'b0010;
    tick();
    clear_src();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL transp_single_write: got %0b expected 0", wr_en); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL transp_end_busy: got %0b expected 0", busy); end
  endtask

  // Second frame during src2 RUN, then reset asserted between edges during the restarted pass.
  task automatic test_overrun_and_reset();
    src_enable = 4'hF; frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    src_done = 4'b0001;
    tick();
    clear_src();
    tick();
    src_done = 4'b0010;
    tick();
    clear_src();
    tick();
    n_checks++; if (sel !== 2'd2 || src_ready !== 4'b0100) begin n_fail++; $display("FAIL ovr_run2: got sel=%0d ready=%0h expected sel=2 ready=4", sel, src_ready); end
    src_valid = 4'b0100;
    set_pix(2, 10'd11, 10'd22, 9'h055);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    clear_src();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %0b expected 1", overrun); end
    n_checks++; if (sel !== 2'd0 || src_ready !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL ovr_restart: got sel=%0d ready=%0h busy=%0b expected sel=0 ready=0 busy=1", sel, src_ready, busy); end
    n_checks++;
    if (wr_en !== 1'b1 || wr_x !== 10'd11 || wr_y !== 10'd22 || wr_color !== 9'h055) begin
      n_fail++;
      $display("FAIL ovr_write: got en=%0b (%0d,%0d,%0h) expected en=1 (11,22,55)", wr_en, wr_x, wr_y, wr_color);
    end
    tick();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_single: got %0b expected 0", overrun); end
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL ovr_run0: got %0h expected 1", src_ready); end
    src_valid = 4'b0001;
    set_pix(0, 10'd1, 10'd2, 9'h003);
    tick();
    n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_write: got %0b expected 1", wr_en); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (wr_en !== 1'b0 || src_ready !== 4'h0 || busy !== 1'b0 || wr_x !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_async: got wr_en=%0b ready=%0h busy=%0b wr_x=%0d expected all 0", wr_en, src_ready, busy, wr_x);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_quiet cycle%0d: got wr_en=%0b busy=%0b expected 0 0", i, wr_en, busy); end
    end
    clear_src();
  endtask

`ifdef FRAME_WRITE_TIMEOUT_EN
  task automatic test_timeout();
    src_enable = 4'b0001; frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL to_run0: got %0h expected 1", src_ready); end
    for (int k = 1; k < 16; k++) begin
      tick();
      n_checks++; if (timeout !== 1'b0 || src_ready !== 4'b0001) begin n_fail++; $display("FAIL to_early cycle%0d: got timeout=%0b ready=%0h expected 0 1", k, timeout, src_ready); end
    end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %0b expected 1", timeout); end
    n_checks++; if (sel !== 2'd1 || overrun !== 1'b0) begin n_fail++; $display("FAIL to_advance: got sel=%0d overrun=%0b expected 1 0", sel, overrun); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_single: got %0b expected 0", timeout); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_end_busy: got %0b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_pass();
    test_skip();
    test_transparent();
    test_overrun_and_reset();
`ifdef FRAME_WRITE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_write_sequencer.md
FRAME_WRITE_SEQUENCER -- requirements
Module: frame_write_sequencer

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 4: number of draw sources, 2..16.
REQ-002 SHALL have parameter COLOR_DEPTH, default 9: pixel colour width in bits.
REQ-003 SHALL have parameter COORD_W, default 10: x/y coordinate width in bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in cycles, used only per REQ-031.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port frame, input, 1: single-cycle pulse that starts a draw pass.
REQ-008 SHALL have port src_enable, input, NUM_SOURCES: per-source participation mask, sampled at slot selection.
REQ-009 SHALL have ports src_valid, src_done and src_transparent, each input, NUM_SOURCES: per-source pixel valid, end-of-source and skip-write flags.
REQ-010 SHALL have ports src_x, src_y, input, NUM_SOURCES*COORD_W each; src_color, input, NUM_SOURCES*COLOR_DEPTH: packed data, source i in slice i.
REQ-011 SHALL have port src_ready, output, NUM_SOURCES: one-hot or zero; the granted source may transfer.
REQ-012 SHALL have port sel, output, clog2(NUM_SOURCES): index of the current slot.
REQ-013 SHALL have ports wr_en, output, 1; wr_x, wr_y, output, COORD_W; wr_color, output, COLOR_DEPTH: registered framebuffer write port.
REQ-014 SHALL have ports busy, output, 1 (pass in progress) and overrun, output, 1 (single-cycle pulse).

Function
REQ-015 SHALL implement FSM states IDLE, SELECT and RUN.
REQ-016 IDLE SHALL transition to SELECT on frame=1, with sel loaded to 0 and busy asserted from the next cycle.
REQ-017 SELECT SHALL go to RUN when src_enable[sel]=1; otherwise it SHALL increment sel and stay in SELECT, taking 1 cycle per skipped source.
REQ-018 SELECT with sel=NUM_SOURCES-1 and that source disabled SHALL go to IDLE and deassert busy.
REQ-019 In RUN, src_ready[sel] SHALL be 1 and every other src_ready bit SHALL be 0; outside RUN, src_ready SHALL be all zero.
REQ-020 A transfer SHALL occur on a cycle with src_valid[sel] and src_ready[sel] both high.
REQ-021 A transfer with src_transparent[sel]=0 SHALL produce wr_en=1 on the next cycle, with that source's x/y/color registered; latency is exactly 1 cycle and throughput 1 pixel per cycle.
REQ-022 A transfer with src_transparent[sel]=1 SHALL be consumed with no write (wr_en=0).
REQ-023 src_done[sel] in RUN SHALL end the slot.
    - done and valid in the same cycle: the pixel is still transferred.
    - next state: SELECT with sel+1, or IDLE if sel=NUM_SOURCES-1.
REQ-024 wr_en SHALL be 1 for exactly one cycle per non-transparent transfer and 0 at all other times.
REQ-025 frame=1 while busy=1 SHALL pulse overrun for 1 cycle, abandon the current slot, and restart at SELECT with sel=0.
    - A transfer in that same cycle is still written.
REQ-026 Signals of non-granted sources SHALL be ignored.
REQ-027 Source order SHALL be fixed ascending index, so higher indices overdraw lower ones.

Reset
REQ-028 While reset=1, the block SHALL be in IDLE with sel=0, busy=0, overrun=0, wr_en=0, wr_x=0, wr_y=0, wr_color=0 and src_ready=0, regardless of clk.
REQ-029 Reset asserted mid-pass SHALL drop the pass with no further writes; a frame pulse coincident with reset SHALL be ignored.

Configuration
REQ-030 Macro FRAME_WRITE_TIMEOUT_EN SHALL control a per-slot watchdog.
REQ-031 With FRAME_WRITE_TIMEOUT_EN defined:
    - a counter SHALL clear on RUN entry and increment each RUN cycle.
    - at TIMEOUT_CYCLES-1 without done, the slot SHALL be force-ended as in REQ-023, and port timeout (output, 1) SHALL pulse for 1 cycle.
REQ-032 Without FRAME_WRITE_TIMEOUT_EN, there SHALL be no counter and no timeout port; a slot lasts until done, frame or reset.

Verification
REQ-033 NUM_SOURCES=4, enable=4'b1111, each source sends 3 opaque pixels then done -> 12 wr_en pulses in order src0..src3, each 1 cycle after its handshake; busy falls after src3's done.
REQ-034 enable=4'b1010 -> sel steps 0 (skip), 1 (RUN), 2 (skip), 3 (RUN); src_ready[0] and src_ready[2] are never asserted.
REQ-035 src1 sends pixel (5,7,9'h1FF) transparent, then (6,7,9'h0AA) opaque -> exactly one write: wr_x=6, wr_y=7, wr_color=9'h0AA.
REQ-036 Second frame pulse during src2 RUN -> overrun=1 for 1 cycle; sel=0 on the next cycle; a pixel transferred in the pulse cycle is still written.
REQ-037 reset asserted between clock edges during RUN -> wr_en, src_ready and busy are 0 immediately; no wr_en after release until a new frame pulse.
REQ-038 FRAME_WRITE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, src0 never asserts done -> timeout pulses 16 cycles after RUN entry, sel advances to 1, and no overrun is raised.
